// File: rtl/calc_pkg.sv
// Shared command and state encodings for the serial accumulator calculator.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/hex_decoder.sv
// Nibble to seven-segment decoder for the board HEX displays.
// Segments are {g,f,e,d,c,b,a}, active-low (0 lights a segment).
module hex_decoder (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_nibble)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/serial_adder_bit.sv
// Single full-adder cell; the accumulator pushes one bit per clock through it.
module serial_adder_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c_in,
  output logic o_s,
  output logic o_c_out
);

  assign o_s     = i_a ^ i_b ^ i_c_in;
  assign o_c_out = (i_a & i_b) | (i_a & i_c_in) | (i_b & i_c_in);

endmodule

// File: rtl/serial_accumulator_calculator.sv
// WIDTH-bit accumulator with LOAD/CLEAR/ADD/SUB; ADD and SUB run one bit per clock.
// Handshake: i_start is taken only in IDLE; o_done pulses once when o_acc and flags are valid.
module serial_accumulator_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [1:0]               i_op,
  input  logic [WIDTH-1:0]         i_operand,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [WIDTH-1:0]         o_acc,
  output logic                     o_carry,
  output logic                     o_overflow,
  output logic [(WIDTH/4)*7-1:0]   o_display
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CNT_W  = $clog2(WIDTH);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic             r_c;
  logic             r_sub;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             r_ovf;
  logic             r_done;

  logic             w_s;
  logic             w_c_out;
  logic             w_last;

  serial_adder_bit u_bit (
    .i_a     (r_a[0]),
    .i_b     (r_b[0]),
    .i_c_in  (r_c),
    .o_s     (w_s),
    .o_c_out (w_c_out)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_sub   <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            case (op_e'(i_op))
              OP_LOAD: begin
                r_acc   <= i_operand;
                r_carry <= 1'b0;
                r_ovf   <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
              OP_CLEAR: begin
                r_acc   <= '0;
                r_carry <= 1'b0;
                r_ovf   <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
              default: begin
                // SUB is A + ~B + 1: invert the operand and seed the carry.
                r_a     <= r_acc;
                r_b     <= (i_op == OP_SUB) ? ~i_operand : i_operand;
                r_c     <= (i_op == OP_SUB);
                r_sub   <= (i_op == OP_SUB);
                r_res   <= '0;
                r_cnt   <= '0;
                r_state <= ST_RUN;
              end
            endcase
          end
        end
        ST_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= {w_s, r_res[WIDTH-2:1]};
          r_c   <= w_c_out;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // On the last bit r_a[0]/r_b[0] still hold the operand sign bits.
            r_acc   <= {w_s, r_res};
            r_carry <= w_c_out ^ r_sub;
            r_ovf   <= (r_a[0] == r_b[0]) && (w_s != r_a[0]);
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state == ST_RUN);
  assign o_done     = r_done;
  assign o_acc      = r_acc;
  assign o_carry    = r_carry;
  assign o_overflow = r_ovf;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    hex_decoder u_dec (
      .i_nibble (r_acc[4*k +: 4]),
      .o_seg    (o_display[7*k +: 7])
    );
  end

endmodule
